// File: rtl/johnson_phase_decoder_pkg.sv
// Shared types and helpers for the Johnson phase decoder slice.
//   state_t : tracking FSM states
//   pw(n)   : phase index width for an n-bit Johnson code (2n phases)
package johnson_phase_decoder_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        RESYNC = 2'd3
    } state_t;

    function automatic int pw(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder, usable by any Johnson counter consumer.
// Ports:
//   code_i  [N-1:0]  Johnson code
//   legal_o          code is one of the 2N legal Johnson states
//   phase_o [PW-1:0] decoded phase (0 when illegal)
module johnson_code_decode
    import johnson_phase_decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      code_i,
    output logic              legal_o,
    output logic [pw(N)-1:0]  phase_o
);

    localparam int PW = pw(N);

    // k ones packed into the MSBs
    function automatic logic [N-1:0] upper_ones(input int k);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= N - k) v[i] = 1'b1;
        end
        return v;
    endfunction

    // m ones packed into the LSBs
    function automatic logic [N-1:0] lower_ones(input int m);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i < m) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        legal_o = 1'b0;
        phase_o = '0;
        // Filling half of the ring: phases 0..N
        for (int k = 0; k <= N; k++) begin
            if (code_i == upper_ones(k)) begin
                legal_o = 1'b1;
                phase_o = PW'(k);
            end
        end
        // Draining half of the ring: phases N+1..2N-1
        for (int m = 1; m < N; m++) begin
            if (code_i == lower_ones(m)) begin
                legal_o = 1'b1;
                phase_o = PW'(2 * N - m);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: decodes sampled Johnson codes into a phase index and
// one-hot strobe, checks legality and successor order, tracks lock, counts
// errors and completed rings, and requests a counter resync on loss of lock.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en_i              sample code_in_i this cycle
//   code_in_i [N]     Johnson code from the counter
//   phase_idx_o       decoded phase (holds on illegal code)
//   phase_onehot_o    one-hot of phase, zero on illegal code
//   code_ok_o         last sample was legal
//   step_err_o        one-cycle pulse on illegal code or wrong successor
//   locked_o          FSM is in LOCKED
//   err_cnt_o         saturating step_err count
//   cycle_cnt_o       wrapping count of 2N-1 -> 0 steps while LOCKED
//   resync_o          counter reset request, held RESYNC_LEN cycles
//
// state  | meaning
// ACQ    | waiting for any legal code to seed the previous phase
// TRACK  | counting consecutive good steps toward lock
// LOCKED | locked; consecutive bad samples counted toward resync
// RESYNC | resync_o high for RESYNC_LEN cycles, inputs ignored
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_TH    = 4,
    parameter int MISS_TH    = 2,
    parameter int RESYNC_LEN = 2,
    parameter int ERR_W      = 8,
    parameter int CYC_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [N-1:0]       code_in_i,
    output logic [pw(N)-1:0]   phase_idx_o,
    output logic [2*N-1:0]     phase_onehot_o,
    output logic               code_ok_o,
    output logic               step_err_o,
    output logic               locked_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic [CYC_W-1:0]   cycle_cnt_o,
    output logic               resync_o
);

    localparam int PW = pw(N);
    localparam int P  = 2 * N;
    localparam int GW = $clog2(LOCK_TH + 1);
    localparam int MW = $clog2(MISS_TH + 1);
    localparam int RW = $clog2(RESYNC_LEN + 1);

    localparam logic [GW-1:0] LOCK_TH_C = GW'(LOCK_TH);
    localparam logic [MW-1:0] MISS_TH_C = MW'(MISS_TH);
    localparam logic [RW-1:0] RS_LOAD_C = RW'(RESYNC_LEN - 1);
    localparam logic [PW-1:0] LAST_PH_C = PW'(P - 1);
    localparam logic [P-1:0]  ONE_C     = P'(1);

    logic              dec_legal;
    logic [PW-1:0]     dec_phase;

    state_t            state_q, state_d;
    logic [PW-1:0]     prev_q, prev_d;
    logic [GW-1:0]     good_q, good_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic [RW-1:0]     rs_q, rs_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic [P-1:0]      onehot_q, onehot_d;
    logic              ok_q, ok_d;
    logic              step_q, step_d;
    logic              locked_q, locked_d;
    logic              resync_q, resync_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;

    logic [PW-1:0]     succ;
    logic              good_step;
    logic [GW-1:0]     good_inc;
    logic [MW-1:0]     miss_inc;

    johnson_code_decode #(.N(N)) u_dec (
        .code_i  (code_in_i),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        good_d   = good_q;
        miss_d   = miss_q;
        rs_d     = rs_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ok_d     = ok_q;
        step_d   = 1'b0;
        err_d    = err_q;
        cyc_d    = cyc_q;

        succ      = (prev_q == LAST_PH_C) ? '0 : prev_q + 1'b1;
        good_step = dec_legal && (dec_phase == succ);
        good_inc  = good_q + 1'b1;
        miss_inc  = miss_q + 1'b1;

        if (state_q == RESYNC) begin
            // rs_q is a down-counter; terminal count ends the request
            if (rs_q == '0) begin
                state_d = ACQ;
                good_d  = '0;
                miss_d  = '0;
            end else begin
                rs_d = rs_q - 1'b1;
            end
        end else if (en_i) begin
            ok_d = dec_legal;
            if (dec_legal) begin
                idx_d    = dec_phase;
                onehot_d = ONE_C << dec_phase;
            end else begin
                onehot_d = '0;
            end

            case (state_q)
                ACQ: begin
                    if (dec_legal) begin
                        prev_d  = dec_phase;
                        good_d  = '0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!dec_legal) begin
                        step_d  = 1'b1;
                        state_d = ACQ;
                    end else if (good_step) begin
                        prev_d = dec_phase;
                        good_d = good_inc;
                        if (good_inc == LOCK_TH_C) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        step_d = 1'b1;
                        prev_d = dec_phase;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Once locked, any legal code becomes the reference phase
                    if (dec_legal) prev_d = dec_phase;
                    if (good_step) begin
                        miss_d = '0;
                        if (prev_q == LAST_PH_C) cyc_d = cyc_q + 1'b1;
                    end else begin
                        step_d = 1'b1;
                        miss_d = miss_inc;
                        if (miss_inc == MISS_TH_C) begin
                            state_d = RESYNC;
                            rs_d    = RS_LOAD_C;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (step_d && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;

        locked_d = (state_d == LOCKED);
        resync_d = (state_d == RESYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACQ;
            prev_q   <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            rs_q     <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            ok_q     <= 1'b0;
            step_q   <= 1'b0;
            locked_q <= 1'b0;
            resync_q <= 1'b0;
            err_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            rs_q     <= rs_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ok_q     <= ok_d;
            step_q   <= step_d;
            locked_q <= locked_d;
            resync_q <= resync_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
        end
    end

    assign phase_idx_o    = idx_q;
    assign phase_onehot_o = onehot_q;
    assign code_ok_o      = ok_q;
    assign step_err_o     = step_q;
    assign locked_o       = locked_q;
    assign resync_o       = resync_q;
    assign err_cnt_o      = err_q;
    assign cycle_cnt_o    = cyc_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder with a reference model feeding a
// scoreboard of expected output vectors.
module tb_johnson_phase_decoder;

    localparam int N          = 4;
    localparam int P          = 2 * N;
    localparam int PW         = $clog2(P);
    localparam int LOCK_TH    = 4;
    localparam int MISS_TH    = 2;
    localparam int RESYNC_LEN = 2;
    localparam int ERR_W      = 8;
    localparam int CYC_W      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [N-1:0]      code = '0;
    logic [PW-1:0]     phase_idx;
    logic [P-1:0]      phase_onehot;
    logic              code_ok, step_err, locked, resync;
    logic [ERR_W-1:0]  err_cnt;
    logic [CYC_W-1:0]  cycle_cnt;

    johnson_phase_decoder #(
        .N(N), .LOCK_TH(LOCK_TH), .MISS_TH(MISS_TH),
        .RESYNC_LEN(RESYNC_LEN), .ERR_W(ERR_W), .CYC_W(CYC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en),
        .code_in_i      (code),
        .phase_idx_o    (phase_idx),
        .phase_onehot_o (phase_onehot),
        .code_ok_o      (code_ok),
        .step_err_o     (step_err),
        .locked_o       (locked),
        .err_cnt_o      (err_cnt),
        .cycle_cnt_o    (cycle_cnt),
        .resync_o       (resync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]    idx;
        logic [P-1:0]     onehot;
        logic             ok;
        logic             step;
        logic             lck;
        logic             rsy;
        logic [ERR_W-1:0] err;
        logic [CYC_W-1:0] cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference ring built by running a Johnson counter: MSB <- ~LSB, shift right
    logic [N-1:0] ring [P];
    int pos;

    // Model state: 0 ACQ, 1 TRACK, 2 LOCKED, 3 RESYNC
    int m_state, m_prev, m_good, m_miss, m_rs;
    exp_t m_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic [N-1:0] c);
        int  ph;
        bit  legal;
        bit  good;
        bit  stp;
        legal = 0;
        ph    = 0;
        stp   = 0;
        for (int i = 0; i < P; i++) begin
            if (ring[i] == c) begin
                legal = 1;
                ph    = i;
            end
        end
        if (r) begin
            m_state = 0; m_prev = 0; m_good = 0; m_miss = 0; m_rs = 0;
            m_out.idx = '0; m_out.onehot = '0; m_out.ok = 0;
            m_out.err = '0; m_out.cyc = '0;
        end else if (m_state == 3) begin
            if (m_rs == 0) begin
                m_state = 0; m_good = 0; m_miss = 0;
            end else begin
                m_rs--;
            end
        end else if (e) begin
            m_out.ok = legal;
            if (legal) begin
                m_out.idx    = PW'(ph);
                m_out.onehot = P'(1) << ph;
            end else begin
                m_out.onehot = '0;
            end
            good = legal && (ph == (m_prev + 1) % P);
            if (m_state == 0) begin
                if (legal) begin
                    m_prev = ph; m_good = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (!legal) begin
                    stp = 1; m_state = 0;
                end else if (good) begin
                    m_prev = ph;
                    m_good++;
                    if (m_good >= LOCK_TH) begin
                        m_state = 2; m_miss = 0;
                    end
                end else begin
                    stp = 1; m_prev = ph; m_good = 0;
                end
            end else begin
                if (good) begin
                    if (m_prev == P - 1) m_out.cyc = m_out.cyc + 1'b1;
                    m_miss = 0;
                end else begin
                    stp = 1;
                    m_miss++;
                end
                if (legal) m_prev = ph;
                if (m_miss >= MISS_TH) begin
                    m_state = 3; m_rs = RESYNC_LEN - 1;
                end
            end
        end
        if (stp && m_out.err != {ERR_W{1'b1}}) m_out.err = m_out.err + 1'b1;
        m_out.step = stp;
        m_out.lck  = (m_state == 2);
        m_out.rsy  = (m_state == 3);
    endtask

    // One clock: drive, push expectation, clock, pop and compare
    task automatic step(input logic r, input logic e, input logic [N-1:0] c);
        exp_t x;
        rst  = r;
        en   = e;
        code = c;
        model(r, e, c);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("phase_idx",    32'(phase_idx),    32'(x.idx));
        chk("phase_onehot", 32'(phase_onehot), 32'(x.onehot));
        chk("code_ok",      32'(code_ok),      32'(x.ok));
        chk("step_err",     32'(step_err),     32'(x.step));
        chk("locked",       32'(locked),       32'(x.lck));
        chk("resync",       32'(resync),       32'(x.rsy));
        chk("err_cnt",      32'(err_cnt),      32'(x.err));
        chk("cycle_cnt",    32'(cycle_cnt),    32'(x.cyc));
    endtask

    task automatic feed();
        step(1'b0, 1'b1, ring[pos]);
        pos = (pos + 1) % P;
    endtask

    initial begin
        ring[0] = '0;
        for (int i = 1; i < P; i++) ring[i] = {~ring[i-1][0], ring[i-1][N-1:1]};

        // Reset state
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("rst_locked", 32'(locked), 32'd0);

        // Acquire from 0001 and lock after 5 samples
        pos = P - 1;
        for (int i = 0; i < 4; i++) feed();
        chk("not_locked_yet", 32'(locked), 32'd0);
        feed();
        chk("locked_after_5", 32'(locked), 32'd1);
        chk("err_zero", 32'(err_cnt), 32'd0);

        // Three full rings while locked
        for (int i = 0; i < 3 * P; i++) feed();
        chk("cycles_3", 32'(cycle_cnt), 32'd3);

        // Single illegal sample
        step(1'b0, 1'b1, 4'b1010);
        chk("single_bad_onehot", 32'(phase_onehot), 32'd0);
        for (int i = 0; i < 3; i++) feed();
        chk("single_bad_locked", 32'(locked), 32'd1);

        // Two illegal samples -> resync, then relock
        step(1'b0, 1'b1, 4'b1010);
        step(1'b0, 1'b1, 4'b1010);
        chk("resync_up", 32'(resync), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1010);
        chk("resync_done", 32'(resync), 32'd0);
        for (int i = 0; i < 5; i++) feed();
        chk("relocked", 32'(locked), 32'd1);

        // Skip a phase: 1100 -> 1111 -> 0111
        for (int i = 0; i < P && pos != 2; i++) feed();
        feed();
        step(1'b0, 1'b1, ring[4]);
        chk("skip_idx", 32'(phase_idx), 32'd4);
        pos = 5;
        for (int i = 0; i < 3; i++) feed();

        // Reset during resync
        step(1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b0, 4'b0101);
        step(1'b1, 1'b1, 4'b0101);
        chk("rst_in_resync", 32'(resync), 32'd0);

        // Relock, then hold en low mid-ring, then resume
        for (int i = 0; i < 6; i++) feed();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b1010);
        for (int i = 0; i < 4; i++) feed();
        chk("en_hold_locked", 32'(locked), 32'd1);

        // Error counter saturation: legal (ACQ->TRACK) then illegal, repeated
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, ring[0]);
            step(1'b0, 1'b1, 4'b0110);
        end
        chk("err_saturated", 32'(err_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the team's N-bit Johnson counter output; converts each sampled Johnson code into a binary phase index and a one-hot phase strobe.
- Checks every code for legality and checks that each code is the correct successor of the previous one.
- Tracks lock, counts errors and completed cycles, and raises a resync pulse that the integrator routes back to the counter's rst.

Parameters:
- N, 4, Johnson code width (>=2); 2N phases.
- LOCK_TH, 4, consecutive good steps required to enter LOCKED (>=1).
- MISS_TH, 2, consecutive bad samples in LOCKED that trigger RESYNC (>=1).
- RESYNC_LEN, 2, cycles resync is held high (>=1).
- ERR_W, 8, width of saturating error counter.
- CYC_W, 16, width of wrapping cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  sample code_in this cycle
- code_in  in  N  Johnson code from counter
- phase_idx  out  PW=$clog2(2N)  decoded phase
- phase_onehot  out  2N  one-hot of phase_idx, qualified by code_ok
- code_ok  out  1  last sample was a legal code
- step_err  out  1  one-cycle pulse: illegal code or wrong successor
- locked  out  1  state==LOCKED
- err_cnt  out  ERR_W  saturating count of step_err pulses
- cycle_cnt  out  CYC_W  wrapping count of phase 2N-1 -> 0 transitions while LOCKED
- resync  out  1  request to reset the Johnson counter

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: phase_idx=0, phase_onehot=0, code_ok=0, step_err=0, locked=0, err_cnt=0, cycle_cnt=0, resync=0. State after reset is ACQ.
- Latency: outputs reflect the en-qualified sample one clock after it is taken. When en=0, all outputs hold, except that step_err and resync pulses drop and resync timing still advances.
- Decode: all-upper-ones with k ones in the MSBs (k=0..N) gives phase k. All-lower-ones with m ones in the LSBs (m=1..N-1) gives phase 2N-m. Any other pattern is illegal. For N=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Illegal code: code_ok=0, phase_onehot=0, phase_idx holds.
- Good step: code is legal and phase == (prev_phase+1) mod 2N. prev_phase is the last legal decoded phase.
- ACQ:
  - step_err is never raised.
  - A legal code loads prev_phase, clears good_cnt, and moves to TRACK.
  - An illegal code stays in ACQ.
- TRACK:
  - A good step increments good_cnt; on reaching LOCK_TH, move to LOCKED.
  - A legal wrong-successor code pulses step_err, reloads prev_phase, and clears good_cnt.
  - An illegal code pulses step_err and returns to ACQ.
- LOCKED:
  - A good step clears miss_cnt.
  - A bad sample pulses step_err and increments miss_cnt.
  - A legal code is always accepted as the new phase, even if it is the wrong successor.
  - When miss_cnt reaches MISS_TH, move to RESYNC.
- RESYNC:
  - locked=0 and resync=1 for exactly RESYNC_LEN cycles, independent of en; inputs are ignored.
  - Then go to ACQ with good_cnt=miss_cnt=0. err_cnt and cycle_cnt are preserved.
- err_cnt increments on each step_err pulse and saturates at all-ones.
- cycle_cnt increments on a good step from 2N-1 to 0 while in LOCKED, and wraps modulo 2^CYC_W.
- rst asserted mid-operation (including during RESYNC) returns everything to reset values on the next edge.

Decomposition:
- Shared package: state enum {ACQ, TRACK, LOCKED, RESYNC} and function PW(N)=$clog2(2N).
- One sub-module, johnson_code_decode: purely combinational; code -> {legal, phase}. It is reusable by other Johnson consumers.

Test Plan:
- Reset then en=1, feed a true counter sequence starting at 0001 -> phase_idx 7,0,1,2,… one cycle later; locked=1 after the 5th sample (1 acquire + 4 good steps); err_cnt=0.
- Locked, run 3 full rings -> cycle_cnt increments on each 7->0 step; phase_onehot=8'b0000_0001 when phase 0.
- Locked, inject 1010 once, then resume the correct sequence -> step_err one pulse, code_ok=0, phase_onehot=0, err_cnt=1, locked stays 1.
- Locked, inject 1010 twice consecutively -> err_cnt=2, locked=0, resync high exactly 2 cycles, then ACQ; relock after 5 good samples.
- Locked, skip a phase (1100 -> 1111) -> step_err pulse, phase_idx=4, miss_cnt cleared by the next good step 0111.
- Assert rst during resync; separately, hold en=0 for 5 cycles mid-ring -> rst: all outputs zero next cycle; en=0: outputs held, resumes correctly.
